// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/check/writeback bundle for the register scoreboard
// Purpose: groups the issue, source-check and writeback inputs with the busy outputs.
// Signals:
//   issue_valid/issue_long/issue_rd/issue_rd_fp : op leaving ID into EXE
//   chk_rs1..3 / chk_rs1..3_fp / chk_rs3_en      : sources of the op in ID
//   wb_valid/wb_rd/wb_rd_fp                      : long-unit result accepted
//   rd_busy, busy_int, busy_fp, pending_cnt, sb_error : scoreboard outputs
// Modports: master drives issue/check/wb and observes outputs; slave is the scoreboard.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic        issue_rd_fp;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rs3;
    logic        chk_rs1_fp;
    logic        chk_rs2_fp;
    logic        chk_rs3_fp;
    logic        chk_rs3_en;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_rd_fp;
    logic        rd_busy;
    logic [31:0] busy_int;
    logic [31:0] busy_fp;
    logic [3:0]  pending_cnt;
    logic        sb_error;

    modport master (
        output issue_valid, issue_long, issue_rd, issue_rd_fp,
        output chk_rs1, chk_rs2, chk_rs3, chk_rs1_fp, chk_rs2_fp, chk_rs3_fp, chk_rs3_en,
        output wb_valid, wb_rd, wb_rd_fp,
        input  rd_busy, busy_int, busy_fp, pending_cnt, sb_error
    );

    modport slave (
        input  issue_valid, issue_long, issue_rd, issue_rd_fp,
        input  chk_rs1, chk_rs2, chk_rs3, chk_rs1_fp, chk_rs2_fp, chk_rs3_fp, chk_rs3_en,
        input  wb_valid, wb_rd, wb_rd_fp,
        output rd_busy, busy_int, busy_fp, pending_cnt, sb_error
    );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-op scoreboard for long-latency units
// Purpose: tracks outstanding long ops per integer/FP destination with 2-bit counters
//   and flags RAW/WAW hazards for the instruction in ID.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   sb    : reg_scoreboard_if.slave (issue, source check, writeback, busy outputs)
// Option: SB_WB_BYPASS_EN - a register whose last pending op writes back this cycle
//   reads as not busy for rd_busy in that same cycle.
module reg_scoreboard (
    input  logic              clk,
    input  logic              reset,
    reg_scoreboard_if.slave   sb
);

    logic [1:0]  r_cnt_int [32];
    logic [1:0]  r_cnt_fp  [32];
    logic [31:0] r_busy_int;
    logic [31:0] r_busy_fp;
    logic [3:0]  r_pending;
    logic        r_error;

    logic [1:0]  w_cnt_int_nxt [32];
    logic [1:0]  w_cnt_fp_nxt  [32];
    logic [31:0] w_busy_int_nxt;
    logic [31:0] w_busy_fp_nxt;

    logic        w_issue_valid, w_issue_long, w_issue_rd_fp;
    logic [4:0]  w_issue_rd;
    logic        w_wb_valid, w_wb_rd_fp;
    logic [4:0]  w_wb_rd;

    logic        w_inc_trk, w_dec_trk, w_same;
    logic [1:0]  w_inc_cnt, w_dec_cnt;
    logic        w_inc_ok, w_dec_ok, w_inc_err, w_dec_err;

    assign w_issue_valid = sb.issue_valid;
    assign w_issue_long  = sb.issue_long;
    assign w_issue_rd    = sb.issue_rd;
    assign w_issue_rd_fp = sb.issue_rd_fp;
    assign w_wb_valid    = sb.wb_valid;
    assign w_wb_rd       = sb.wb_rd;
    assign w_wb_rd_fp    = sb.wb_rd_fp;

    // x0 is hardwired zero, so events targeting it are dropped before any bookkeeping
    assign w_inc_trk = w_issue_valid & w_issue_long & (w_issue_rd_fp | (w_issue_rd != 5'd0));
    assign w_dec_trk = w_wb_valid & (w_wb_rd_fp | (w_wb_rd != 5'd0));
    // issue and writeback to the same register cancel out: no change, no error
    assign w_same    = w_inc_trk & w_dec_trk & (w_issue_rd_fp == w_wb_rd_fp) & (w_issue_rd == w_wb_rd);

    assign w_inc_cnt = w_issue_rd_fp ? r_cnt_fp[w_issue_rd] : r_cnt_int[w_issue_rd];
    assign w_dec_cnt = w_wb_rd_fp    ? r_cnt_fp[w_wb_rd]    : r_cnt_int[w_wb_rd];

    assign w_inc_ok  = w_inc_trk & ~w_same & (w_inc_cnt != 2'd3);
    assign w_dec_ok  = w_dec_trk & ~w_same & (w_dec_cnt != 2'd0);
    assign w_inc_err = w_inc_trk & ~w_same & (w_inc_cnt == 2'd3);
    assign w_dec_err = w_dec_trk & ~w_same & (w_dec_cnt == 2'd0);

    // when both are ok they target different registers, so the two updates never collide
    always_comb begin
        w_cnt_int_nxt = r_cnt_int;
        w_cnt_fp_nxt  = r_cnt_fp;
        if (w_inc_ok) begin
            if (w_issue_rd_fp) w_cnt_fp_nxt[w_issue_rd]  = w_inc_cnt + 2'd1;
            else               w_cnt_int_nxt[w_issue_rd] = w_inc_cnt + 2'd1;
        end
        if (w_dec_ok) begin
            if (w_wb_rd_fp) w_cnt_fp_nxt[w_wb_rd]  = w_dec_cnt - 2'd1;
            else            w_cnt_int_nxt[w_wb_rd] = w_dec_cnt - 2'd1;
        end
        for (int i = 0; i < 32; i++) begin
            w_busy_int_nxt[i] = |w_cnt_int_nxt[i];
            w_busy_fp_nxt[i]  = |w_cnt_fp_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_int  <= '{default: 2'd0};
            r_cnt_fp   <= '{default: 2'd0};
            r_busy_int <= '0;
            r_busy_fp  <= '0;
            r_pending  <= '0;
            r_error    <= 1'b0;
        end else begin
            r_cnt_int  <= w_cnt_int_nxt;
            r_cnt_fp   <= w_cnt_fp_nxt;
            r_busy_int <= w_busy_int_nxt;
            r_busy_fp  <= w_busy_fp_nxt;
            if (w_inc_ok && !w_dec_ok && r_pending != 4'd15)
                r_pending <= r_pending + 4'd1;
            else if (w_dec_ok && !w_inc_ok && r_pending != 4'd0)
                r_pending <= r_pending - 4'd1;
            if (w_inc_err || w_dec_err)
                r_error <= 1'b1;
        end
    end

    function automatic logic f_busy(input logic [4:0] r, input logic fp);
        logic b;
        b = fp ? r_busy_fp[r] : r_busy_int[r];
`ifdef SB_WB_BYPASS_EN
        // the last outstanding op completing now frees the register for this cycle's read
        if (w_wb_valid && (w_wb_rd_fp == fp) && (w_wb_rd == r) &&
            ((fp ? r_cnt_fp[r] : r_cnt_int[r]) == 2'd1))
            b = 1'b0;
`endif
        return b;
    endfunction

    assign sb.rd_busy = f_busy(sb.chk_rs1, sb.chk_rs1_fp)
                      | f_busy(sb.chk_rs2, sb.chk_rs2_fp)
                      | (sb.chk_rs3_en & f_busy(sb.chk_rs3, sb.chk_rs3_fp))
                      | f_busy(w_issue_rd, w_issue_rd_fp);

    assign sb.busy_int    = r_busy_int;
    assign sb.busy_fp     = r_busy_fp;
    assign sb.pending_cnt = r_pending;
    assign sb.sb_error    = r_error;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_scoreboard_if sbif ();

    reg_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference: outstanding op count per [file][register], plus totals
    int m_cnt [2][32];
    int m_pend;
    bit m_err;

    function automatic void model_clear();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 32; r++) m_cnt[f][r] = 0;
        m_pend = 0;
        m_err  = 0;
    endfunction

    function automatic void model_update();
        int  ifp, ir, wfp, wr, d;
        bit  inc, dec;
        if (reset) begin
            model_clear();
            return;
        end
        ifp = int'(sbif.issue_rd_fp); ir = int'(sbif.issue_rd);
        wfp = int'(sbif.wb_rd_fp);    wr = int'(sbif.wb_rd);
        inc = sbif.issue_valid && sbif.issue_long && !(ifp == 0 && ir == 0);
        dec = sbif.wb_valid && !(wfp == 0 && wr == 0);
        if (inc && dec && ifp == wfp && ir == wr) return;
        d = 0;
        if (inc) begin
            if (m_cnt[ifp][ir] == 3) m_err = 1;
            else begin m_cnt[ifp][ir]++; d++; end
        end
        if (dec) begin
            if (m_cnt[wfp][wr] == 0) m_err = 1;
            else begin m_cnt[wfp][wr]--; d--; end
        end
        if (d > 0 && m_pend < 15) m_pend++;
        if (d < 0 && m_pend > 0)  m_pend--;
    endfunction

    function automatic bit m_busy(int r, int fp);
        if (m_cnt[fp][r] == 0) return 0;
        if (BYP && sbif.wb_valid && int'(sbif.wb_rd_fp) == fp && int'(sbif.wb_rd) == r &&
            m_cnt[fp][r] == 1) return 0;
        return 1;
    endfunction

    function automatic bit m_rd_busy();
        return m_busy(int'(sbif.chk_rs1), int'(sbif.chk_rs1_fp)) ||
               m_busy(int'(sbif.chk_rs2), int'(sbif.chk_rs2_fp)) ||
               (sbif.chk_rs3_en && m_busy(int'(sbif.chk_rs3), int'(sbif.chk_rs3_fp))) ||
               m_busy(int'(sbif.issue_rd), int'(sbif.issue_rd_fp));
    endfunction

    task automatic idle();
        sbif.issue_valid = 0; sbif.issue_long = 0; sbif.issue_rd = 0; sbif.issue_rd_fp = 0;
        sbif.chk_rs1 = 0; sbif.chk_rs2 = 0; sbif.chk_rs3 = 0;
        sbif.chk_rs1_fp = 0; sbif.chk_rs2_fp = 0; sbif.chk_rs3_fp = 0; sbif.chk_rs3_en = 0;
        sbif.wb_valid = 0; sbif.wb_rd = 0; sbif.wb_rd_fp = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic fp);
        sbif.issue_valid = 1; sbif.issue_long = 1; sbif.issue_rd = rd; sbif.issue_rd_fp = fp;
    endtask

    task automatic wb(input logic [4:0] rd, input logic fp);
        sbif.wb_valid = 1; sbif.wb_rd = rd; sbif.wb_rd_fp = fp;
    endtask

    // advance one edge; returns at the following negedge with the model updated
    task automatic clk_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        issue(5'd4, 1'b0); wb(5'd6, 1'b1);
        clk_cycle();
        clk_cycle();
        reset = 0;
        idle();
        sbif.chk_rs1 = 4; sbif.chk_rs2 = 6; sbif.chk_rs2_fp = 1;
        sbif.chk_rs3 = 4; sbif.chk_rs3_en = 1; sbif.issue_rd = 4;
        #1;
        n_cmp++; if (sbif.busy_int !== 32'h0) begin n_fail++; $display("FAIL reset_busy_int got=%h exp=0", sbif.busy_int); end
        n_cmp++; if (sbif.busy_fp !== 32'h0) begin n_fail++; $display("FAIL reset_busy_fp got=%h exp=0", sbif.busy_fp); end
        n_cmp++; if (sbif.pending_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", sbif.pending_cnt); end
        n_cmp++; if (sbif.sb_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", sbif.sb_error); end
        n_cmp++; if (sbif.rd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rd_busy got=%b exp=0", sbif.rd_busy); end
        idle();
    endtask

    task automatic test_raw();
        idle(); issue(5'd5, 1'b0);
        clk_cycle();
        idle(); sbif.chk_rs1 = 5;
        #1;
        n_cmp++; if (sbif.rd_busy !== 1'b1) begin n_fail++; $display("FAIL raw_rd_busy got=%b exp=1", sbif.rd_busy); end
        n_cmp++; if (sbif.busy_int[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy5 got=%b exp=1", sbif.busy_int[5]); end
        n_cmp++; if (sbif.pending_cnt !== 4'd1) begin n_fail++; $display("FAIL raw_pending got=%0d exp=1", sbif.pending_cnt); end
        wb(5'd5, 1'b0);
        #1;
        n_cmp++; if (sbif.rd_busy !== !BYP) begin n_fail++; $display("FAIL raw_wb_same_cycle got=%b exp=%b", sbif.rd_busy, !BYP); end
        clk_cycle();
        sbif.wb_valid = 0;
        #1;
        n_cmp++; if (sbif.rd_busy !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb got=%b exp=0", sbif.rd_busy); end
        n_cmp++; if (sbif.busy_int[5] !== 1'b0) begin n_fail++; $display("FAIL raw_busy5_clear got=%b exp=0", sbif.busy_int[5]); end
        idle();
    endtask

    task automatic test_waw();
        idle(); issue(5'd3, 1'b1);
        clk_cycle();
        #1;
        n_cmp++; if (sbif.rd_busy !== 1'b1) begin n_fail++; $display("FAIL waw_check got=%b exp=1", sbif.rd_busy); end
        clk_cycle();
        idle(); sbif.chk_rs1 = 1; sbif.chk_rs2 = 2; sbif.chk_rs3 = 3; sbif.chk_rs3_fp = 1;
        #1;
        n_cmp++; if (sbif.rd_busy !== 1'b0) begin n_fail++; $display("FAIL waw_rs3_disabled got=%b exp=0", sbif.rd_busy); end
        n_cmp++; if (sbif.pending_cnt !== 4'd2) begin n_fail++; $display("FAIL waw_pending got=%0d exp=2", sbif.pending_cnt); end
        sbif.chk_rs3_en = 1;
        #1;
        n_cmp++; if (sbif.rd_busy !== 1'b1) begin n_fail++; $display("FAIL waw_rs3_enabled got=%b exp=1", sbif.rd_busy); end
        sbif.chk_rs3_en = 0;
        wb(5'd3, 1'b1);
        clk_cycle();
        n_cmp++; if (sbif.busy_fp[3] !== 1'b1) begin n_fail++; $display("FAIL waw_first_wb got=%b exp=1", sbif.busy_fp[3]); end
        clk_cycle();
        sbif.wb_valid = 0;
        n_cmp++; if (sbif.busy_fp[3] !== 1'b0) begin n_fail++; $display("FAIL waw_second_wb got=%b exp=0", sbif.busy_fp[3]); end
        n_cmp++; if (sbif.pending_cnt !== 4'd0) begin n_fail++; $display("FAIL waw_pending_end got=%0d exp=0", sbif.pending_cnt); end
        idle();
    endtask

    task automatic test_x0_underflow();
        idle(); issue(5'd0, 1'b0);
        clk_cycle();
        idle();
        n_cmp++; if (sbif.busy_int[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got=%b exp=0", sbif.busy_int[0]); end
        n_cmp++; if (sbif.pending_cnt !== 4'd0) begin n_fail++; $display("FAIL x0_pending got=%0d exp=0", sbif.pending_cnt); end
        n_cmp++; if (sbif.sb_error !== 1'b0) begin n_fail++; $display("FAIL x0_no_error got=%b exp=0", sbif.sb_error); end
        wb(5'd9, 1'b0);
        clk_cycle();
        idle();
        n_cmp++; if (sbif.sb_error !== 1'b1) begin n_fail++; $display("FAIL underflow_error got=%b exp=1", sbif.sb_error); end
        for (int i = 0; i < 3; i++) clk_cycle();
        n_cmp++; if (sbif.sb_error !== 1'b1) begin n_fail++; $display("FAIL error_sticky got=%b exp=1", sbif.sb_error); end
        n_cmp++; if (sbif.pending_cnt !== 4'd0) begin n_fail++; $display("FAIL underflow_pending got=%0d exp=0", sbif.pending_cnt); end
        // overflow: fourth issue to the same register
        for (int i = 0; i < 4; i++) begin issue(5'd12, 1'b0); clk_cycle(); end
        idle();
        n_cmp++; if (sbif.pending_cnt !== 4'd3) begin n_fail++; $display("FAIL overflow_pending got=%0d exp=3", sbif.pending_cnt); end
        for (int i = 0; i < 3; i++) begin wb(5'd12, 1'b0); clk_cycle(); end
        idle();
        n_cmp++; if (sbif.busy_int[12] !== 1'b0) begin n_fail++; $display("FAIL overflow_drain got=%b exp=0", sbif.busy_int[12]); end
    endtask

    task automatic test_same_cycle_and_reset();
        reset = 1; idle(); clk_cycle(); reset = 0;
        issue(5'd7, 1'b1);
        clk_cycle();
        issue(5'd7, 1'b1); wb(5'd7, 1'b1);
        clk_cycle();
        idle();
        n_cmp++; if (sbif.busy_fp[7] !== 1'b1) begin n_fail++; $display("FAIL same_cycle_busy got=%b exp=1", sbif.busy_fp[7]); end
        n_cmp++; if (sbif.pending_cnt !== 4'd1) begin n_fail++; $display("FAIL same_cycle_pending got=%0d exp=1", sbif.pending_cnt); end
        n_cmp++; if (sbif.sb_error !== 1'b0) begin n_fail++; $display("FAIL same_cycle_error got=%b exp=0", sbif.sb_error); end
        issue(5'd2, 1'b0); clk_cycle();
        issue(5'd3, 1'b0); clk_cycle();
        n_cmp++; if (sbif.pending_cnt !== 4'd3) begin n_fail++; $display("FAIL three_pending got=%0d exp=3", sbif.pending_cnt); end
        reset = 1; issue(5'd4, 1'b0); wb(5'd2, 1'b0);
        clk_cycle();
        reset = 0; idle(); sbif.chk_rs1 = 2; sbif.chk_rs2 = 7; sbif.chk_rs2_fp = 1;
        #1;
        n_cmp++; if (sbif.busy_int !== 32'h0 || sbif.busy_fp !== 32'h0) begin n_fail++; $display("FAIL reset_pending_busy got=%h/%h exp=0/0", sbif.busy_int, sbif.busy_fp); end
        n_cmp++; if (sbif.pending_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_pending_cnt got=%0d exp=0", sbif.pending_cnt); end
        n_cmp++; if (sbif.rd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_pending_rd_busy got=%b exp=0", sbif.rd_busy); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] ebi, ebf;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            sbif.issue_valid = $urandom_range(0, 1);
            sbif.issue_long  = ($urandom_range(0, 3) != 0);
            sbif.issue_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            sbif.issue_rd_fp = $urandom_range(0, 1);
            sbif.wb_valid    = $urandom_range(0, 1);
            sbif.wb_rd       = 5'($urandom_range(0, 3));
            sbif.wb_rd_fp    = $urandom_range(0, 1);
            sbif.chk_rs1     = 5'($urandom_range(0, 3)); sbif.chk_rs1_fp = $urandom_range(0, 1);
            sbif.chk_rs2     = 5'($urandom_range(0, 3)); sbif.chk_rs2_fp = $urandom_range(0, 1);
            sbif.chk_rs3     = 5'($urandom_range(0, 3)); sbif.chk_rs3_fp = $urandom_range(0, 1);
            sbif.chk_rs3_en  = $urandom_range(0, 1);
            #1;
            n_cmp++;
            if (sbif.rd_busy !== m_rd_busy()) begin
                n_fail++; $display("FAIL rand_rd_busy n=%0d got=%b exp=%b", n, sbif.rd_busy, m_rd_busy());
            end
            clk_cycle();
            for (int r = 0; r < 32; r++) begin
                ebi[r] = (m_cnt[0][r] != 0);
                ebf[r] = (m_cnt[1][r] != 0);
            end
            n_cmp++;
            if (sbif.busy_int !== ebi) begin n_fail++; $display("FAIL rand_busy_int n=%0d got=%h exp=%h", n, sbif.busy_int, ebi); end
            n_cmp++;
            if (sbif.busy_fp !== ebf) begin n_fail++; $display("FAIL rand_busy_fp n=%0d got=%h exp=%h", n, sbif.busy_fp, ebf); end
            n_cmp++;
            if (int'(sbif.pending_cnt) != m_pend) begin n_fail++; $display("FAIL rand_pending n=%0d got=%0d exp=%0d", n, sbif.pending_cnt, m_pend); end
            n_cmp++;
            if (sbif.sb_error !== m_err) begin n_fail++; $display("FAIL rand_error n=%0d got=%b exp=%b", n, sbif.sb_error, m_err); end
        end
        reset = 0;
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_raw();
        test_waw();
        test_x0_underflow();
        test_same_cycle_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
